// File: rtl/fft_buf_pkg.sv
// ---------------------------------------------------------------------------
// fft_buf_pkg
// Shared types and helpers for the FFT ping-pong sample buffer.
//   fill_state_t : fill side is either accepting samples (FILL) or holding a
//                  complete frame while the engine still owns the other bank
//                  (WAIT).
//   work_state_t : engine side either has no frame (IDLE) or owns a complete
//                  frame (ACTIVE).
//   bitrev()     : reverses the low 'width' bits of an address.
// ---------------------------------------------------------------------------
package fft_buf_pkg;

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } fill_state_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } work_state_t;

  // Mirror the full 32-bit word, then shift the reversed field down so only
  // the low 'width' bits of the input end up reversed in the low bits of the
  // result. Callers truncate the result to their own address width.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] mirrored;
    mirrored = {<<{value}};
    return mirrored >> (32 - width);
  endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// ---------------------------------------------------------------------------
// fft_bank_ram
// One bank of complex sample storage: DEPTH x (2*WIDTH) with one write port
// and one registered read port. The read register samples the array before
// a same-cycle write lands, so a same-address read returns the old data.
// Ports:
//   clk, reset      : clock, async active-high reset (read register only;
//                     the array itself is never cleared)
//   wr_en/wr_addr   : write strobe and address
//   wr_re/wr_im     : write data
//   rd_en/rd_addr   : read strobe and address; read data updates next cycle
//   rd_re/rd_im     : registered read data, holds when rd_en is low
// ---------------------------------------------------------------------------
module fft_bank_ram #(
  parameter int WIDTH  = 40,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_re,
  input  logic [WIDTH-1:0]  wr_im,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_re,
  output logic [WIDTH-1:0]  rd_im
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [2*WIDTH-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {wr_re, wr_im};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_word <= '0;
    end else if (rd_en) begin
      rd_word <= mem[rd_addr];
    end
  end

  assign rd_re = rd_word[2*WIDTH-1:WIDTH];
  assign rd_im = rd_word[WIDTH-1:0];

endmodule

// File: rtl/fft_pingpong_buf.sv
// ---------------------------------------------------------------------------
// fft_pingpong_buf
// Double-buffered complex sample store between the front-end sample stream
// and the FFT butterfly engine. Bank 'fsel' fills from the stream (natural or
// bit-reversed order); bank 'wsel' belongs to the engine for in-place random
// access. The banks swap when a frame is complete and the engine has released
// its bank (or never had one).
// Ports:
//   clk, reset                 : clock, async active-high reset
//   in_valid/in_ready          : sample stream handshake
//   in_re/in_im                : sample data
//   bitrev_en                  : bit-reversed store order, taken at frame start
//   frame_avail                : engine owns a complete frame
//   eng_addr                   : engine address into the work bank
//   eng_rd_en/eng_wr_en        : engine read / write requests
//   eng_wr_re/eng_wr_im        : engine write data
//   eng_rd_re/eng_rd_im        : registered read data
//   eng_rd_valid               : read data valid (one cycle after request)
//   eng_done                   : engine releases the work bank (pulse)
//   overlap_stall              : fill bank full, waiting on the engine
// ---------------------------------------------------------------------------
module fft_pingpong_buf
  import fft_buf_pkg::*;
#(
  parameter int WIDTH  = 40,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_re,
  input  logic [WIDTH-1:0]  in_im,
  input  logic              bitrev_en,
  output logic              frame_avail,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_rd_en,
  input  logic              eng_wr_en,
  input  logic [WIDTH-1:0]  eng_wr_re,
  input  logic [WIDTH-1:0]  eng_wr_im,
  output logic [WIDTH-1:0]  eng_rd_re,
  output logic [WIDTH-1:0]  eng_rd_im,
  output logic              eng_rd_valid,
  input  logic              eng_done,
  output logic              overlap_stall
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  fill_state_t       fill_state, fill_next;
  work_state_t       work_state, work_next;
  logic              fsel, wsel;
  logic [ADDR_W-1:0] cnt;
  logic              rev_mode;
  logic              rd_sel;
  logic              swap;

  logic              accept;
  logic              last_accept;
  logic              eng_active;
  logic              done_eff;
  logic              mode_now;
  logic [ADDR_W-1:0] fill_addr;

  logic [1:0]        bank_wr_en;
  logic [1:0]        bank_rd_en;
  logic [ADDR_W-1:0] bank_wr_addr [2];
  logic [WIDTH-1:0]  bank_wr_re   [2];
  logic [WIDTH-1:0]  bank_wr_im   [2];
  logic [WIDTH-1:0]  bank_rd_re   [2];
  logic [WIDTH-1:0]  bank_rd_im   [2];

  assign in_ready      = (fill_state == FILL);
  assign overlap_stall = (fill_state == WAIT);
  assign frame_avail   = (work_state == ACTIVE);
  assign eng_active    = (work_state == ACTIVE);

  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (cnt == LAST_IDX);
  // eng_done is only meaningful while the engine actually owns a bank.
  assign done_eff    = eng_done && eng_active;

  // The first sample of a frame uses bitrev_en directly; the rest of the
  // frame follows the mode latched on that first accept.
  assign mode_now  = (cnt == '0) ? bitrev_en : rev_mode;
  assign fill_addr = mode_now ? ADDR_W'(bitrev(32'(cnt), ADDR_W)) : cnt;

  // Next-state logic for both FSMs. A swap hands the just-filled bank to the
  // engine; when it coincides with eng_done the engine stays ACTIVE on the
  // new bank so frame_avail never dips between back-to-back frames.
  always_comb begin
    fill_next = fill_state;
    work_next = work_state;
    swap      = 1'b0;

    unique case (fill_state)
      FILL: begin
        if (last_accept) begin
          if (!eng_active || done_eff) begin
            swap = 1'b1;
          end else begin
            fill_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (done_eff) begin
          swap      = 1'b1;
          fill_next = FILL;
        end
      end
    endcase

    if (swap) begin
      work_next = ACTIVE;
    end else if (done_eff) begin
      work_next = IDLE;
    end
  end

  // State, bank selects, fill counter and read-side bookkeeping. rd_sel
  // remembers which bank served the last effective read so the output mux
  // keeps showing that data even after a swap or while IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_state   <= FILL;
      work_state   <= IDLE;
      fsel         <= 1'b0;
      wsel         <= 1'b1;
      cnt          <= '0;
      rev_mode     <= 1'b0;
      rd_sel       <= 1'b0;
      eng_rd_valid <= 1'b0;
    end else begin
      fill_state <= fill_next;
      work_state <= work_next;
      if (swap) begin
        wsel <= fsel;
        fsel <= ~fsel;
      end
      if (accept) begin
        cnt <= cnt + 1'b1;
        if (cnt == '0) begin
          rev_mode <= bitrev_en;
        end
      end
      eng_rd_valid <= eng_rd_en && eng_active;
      if (eng_rd_en && eng_active) begin
        rd_sel <= wsel;
      end
    end
  end

  // Route fill and engine traffic to the banks. fsel and wsel are always
  // complementary, so the bank that is not filling is the engine's bank.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      if (fsel == 1'(b)) begin
        bank_wr_en[b]   = accept;
        bank_wr_addr[b] = fill_addr;
        bank_wr_re[b]   = in_re;
        bank_wr_im[b]   = in_im;
      end else begin
        bank_wr_en[b]   = eng_wr_en && eng_active;
        bank_wr_addr[b] = eng_addr;
        bank_wr_re[b]   = eng_wr_re;
        bank_wr_im[b]   = eng_wr_im;
      end
      bank_rd_en[b] = eng_rd_en && eng_active && (wsel == 1'(b));
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_bank_ram #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bank_wr_en[g]),
      .wr_addr (bank_wr_addr[g]),
      .wr_re   (bank_wr_re[g]),
      .wr_im   (bank_wr_im[g]),
      .rd_en   (bank_rd_en[g]),
      .rd_addr (eng_addr),
      .rd_re   (bank_rd_re[g]),
      .rd_im   (bank_rd_im[g])
    );
  end

  assign eng_rd_re = rd_sel ? bank_rd_re[1] : bank_rd_re[0];
  assign eng_rd_im = rd_sel ? bank_rd_im[1] : bank_rd_im[0];

endmodule
